// File: rtl/pcint_pkg.sv
// Shared constants, types and address helper for the pin-change interrupt controller.
package pcint_pkg;

    localparam int         N_GRP_MAX      = 4;
    localparam logic [5:0] PCIFR_ADDR_DEF = 6'h1B;
    localparam logic [7:0] PCICR_ADDR_DEF = 8'h68;
    localparam logic [7:0] PCMSK_BASE_DEF = 8'h6B;

    typedef logic [7:0] pcint_grp_t;

    // Addresses below the base wrap to a large offset and so never hit a mask register.
    function automatic logic [7:0] pcmsk_index(input logic [7:0] ramadr, input logic [7:0] base);
        return ramadr - base;
    endfunction

endpackage

// File: rtl/pcint_ctrl_if.sv
// CPU-side register bus of the pin-change controller: I/O space for PCIFR,
// data-memory space for PCICR and PCMSKn.
interface pcint_ctrl_if;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic [7:0] dm_dbus_out;
    logic       dm_out_en;

    modport master (
        output IO_Addr, iore, iowe, dbus_in, ramadr, ramre, ramwe,
        input  dbus_out, out_en, dm_dbus_out, dm_out_en
    );

    modport slave (
        input  IO_Addr, iore, iowe, dbus_in, ramadr, ramre, ramwe,
        output dbus_out, out_en, dm_dbus_out, dm_out_en
    );
endinterface

// File: rtl/pcint_edge_det.sv
// One 8-pin group: synchroniser, history and masked-toggle detector.
// PCINT_GLITCH_FILTER_EN adds a stability check so short pulses are ignored.
module pcint_edge_det
    import pcint_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  pcint_grp_t pin_i,
    input  pcint_grp_t mask_i,
    output logic       hit_o
);

    pcint_grp_t s1_q, s2_q, h_q, cmp;
    logic       hit_q;

`ifdef PCINT_GLITCH_FILTER_EN
    pcint_grp_t f1_q, f2_q, stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_q <= '0;
            f2_q <= '0;
        end else begin
            f1_q <= s2_q;
            f2_q <= f1_q;
        end
    end

    // A new level is accepted only once s2 and both delay stages agree on it.
    always_comb begin
        stable = ~(s2_q ^ f1_q) & ~(f1_q ^ f2_q);
        cmp    = (stable & s2_q) | (~stable & h_q);
    end
`else
    assign cmp = s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            h_q   <= '0;
            hit_q <= 1'b0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            h_q   <= cmp;
            hit_q <= |((cmp ^ h_q) & mask_i);
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller: PCICR/PCIFR/PCMSKn registers, per-group
// toggle detection and interrupt requests. Optional macro: PCINT_GLITCH_FILTER_EN.
module pcint_ctrl
    import pcint_pkg::*;
#(
    parameter int         N_GRP         = N_GRP_MAX,
    parameter logic [5:0] PCIFR_Address = PCIFR_ADDR_DEF,
    parameter logic [7:0] PCICR_Address = PCICR_ADDR_DEF,
    parameter logic [7:0] PCMSK_Base    = PCMSK_BASE_DEF
) (
    input  logic               cp2,
    input  logic               ireset,
    pcint_ctrl_if.slave        bus,
    input  logic [8*N_GRP-1:0] pin_i,
    input  logic [N_GRP-1:0]   irq_ack,
    output logic [N_GRP-1:0]   pcint_irq,
    output logic [N_GRP-1:0]   PCIE,
    output logic [8*N_GRP-1:0] PCINT
);

    logic [N_GRP-1:0] pcicr_q, pcicr_d;
    logic [N_GRP-1:0] pcifr_q, pcifr_d;
    logic [N_GRP-1:0] hit;
    pcint_grp_t       pcmsk_q [N_GRP];
    pcint_grp_t       pcmsk_d [N_GRP];
    logic [7:0]       msk_off;
    logic             pcicr_wr, pcifr_wr;
    logic             dm_hit;
    logic [7:0]       dm_data;

    assign msk_off  = pcmsk_index(bus.ramadr, PCMSK_Base);
    assign pcicr_wr = bus.ramwe && (bus.ramadr == PCICR_Address);
    assign pcifr_wr = bus.iowe && (bus.IO_Addr == PCIFR_Address);

    always_comb begin
        pcicr_d = pcicr_wr ? bus.dbus_in[N_GRP-1:0] : pcicr_q;
        pcifr_d = pcifr_q;
        for (int n = 0; n < N_GRP; n++) begin
            pcmsk_d[n] = (bus.ramwe && msk_off == 8'(n)) ? bus.dbus_in : pcmsk_q[n];
            // A same-cycle set outranks both software write-1 and vector acknowledge.
            pcifr_d[n] = (pcicr_q[n] && hit[n]) ||
                         (pcifr_q[n] && !irq_ack[n] && !(pcifr_wr && bus.dbus_in[n]));
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            pcicr_q <= '0;
            pcifr_q <= '0;
            for (int n = 0; n < N_GRP; n++) pcmsk_q[n] <= '0;
        end else begin
            pcicr_q <= pcicr_d;
            pcifr_q <= pcifr_d;
            for (int n = 0; n < N_GRP; n++) pcmsk_q[n] <= pcmsk_d[n];
        end
    end

    assign bus.out_en   = bus.iore && (bus.IO_Addr == PCIFR_Address);
    assign bus.dbus_out = bus.out_en ? 8'(pcifr_q) : 8'h00;

    always_comb begin
        dm_hit  = 1'b0;
        dm_data = 8'h00;
        if (bus.ramre) begin
            if (bus.ramadr == PCICR_Address) begin
                dm_hit  = 1'b1;
                dm_data = 8'(pcicr_q);
            end
            for (int n = 0; n < N_GRP; n++) begin
                if (msk_off == 8'(n)) begin
                    dm_hit  = 1'b1;
                    dm_data = pcmsk_q[n];
                end
            end
        end
    end

    assign bus.dm_out_en   = dm_hit;
    assign bus.dm_dbus_out = dm_data;

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        pcint_edge_det u_det (
            .clk    (cp2),
            .rst_n  (ireset),
            .pin_i  (pin_i[8*g +: 8]),
            .mask_i (pcmsk_q[g]),
            .hit_o  (hit[g])
        );
        assign PCINT[8*g +: 8] = pcmsk_q[g];
    end

    assign PCIE      = pcicr_q;
    assign pcint_irq = pcifr_q & pcicr_q;

endmodule

// File: tb/tb_pcint_ctrl.sv
// Self-checking bench for pcint_ctrl: register table, hand-written corner
// sequences and a randomized run against a sample-history reference model.
`timescale 1ns/1ps
module tb_pcint_ctrl;
    import pcint_pkg::*;

    localparam int NG = 4;
`ifdef PCINT_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    logic        cp2 = 1'b0;
    logic        ireset = 1'b0;
    logic [31:0] pin_i = '0;
    logic [3:0]  irq_ack = '0;
    logic [3:0]  pcint_irq, PCIE;
    logic [31:0] PCINT;
    int          total = 0;
    int          bad = 0;
    bit          model_on = 1'b0;

    pcint_ctrl_if bus ();

    pcint_ctrl #(.N_GRP(NG)) dut (
        .cp2(cp2), .ireset(ireset), .bus(bus), .pin_i(pin_i), .irq_ack(irq_ack),
        .pcint_irq(pcint_irq), .PCIE(PCIE), .PCINT(PCINT)
    );

    always #5 cp2 = ~cp2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Pins sampled at each edge (p0 newest); accepted pin levels (a0 newest).
    // A change accepted at edge j raises the flag at edge j+2.
    logic [31:0] p0, p1, p2, p3, a0, a1, a2;
    logic [3:0]  pcie_m, flag_m;
    logic [7:0]  msk_m [4];
    logic [7:0]  mskp_m [4];

    task automatic model_reset();
        p0 = '0; p1 = '0; p2 = '0; p3 = '0; a0 = '0; a1 = '0; a2 = '0;
        pcie_m = '0; flag_m = '0;
        for (int g = 0; g < 4; g++) begin msk_m[g] = '0; mskp_m[g] = '0; end
    endtask

    task automatic model_edge();
        logic [3:0]  set, clr;
        logic [31:0] a_new;
        set = '0; clr = '0;
        for (int i = 0; i < 32; i++)
            if (pcie_m[i/8] && mskp_m[i/8][i%8] && (a1[i] != a2[i])) set[i/8] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            clr[g] = irq_ack[g] || (bus.iowe && bus.IO_Addr == 6'h1B && bus.dbus_in[g]);
            if (set[g]) flag_m[g] = 1'b1;
            else if (clr[g]) flag_m[g] = 1'b0;
            mskp_m[g] = msk_m[g];
        end
        if (bus.ramwe) begin
            if (bus.ramadr == 8'h68) pcie_m = bus.dbus_in[3:0];
            for (int g = 0; g < 4; g++)
                if (bus.ramadr == 8'h6B + 8'(g)) msk_m[g] = bus.dbus_in;
        end
        p3 = p2; p2 = p1; p1 = p0; p0 = pin_i;
        for (int i = 0; i < 32; i++) begin
            if (!FILT) a_new[i] = p1[i];
            else if (p1[i] == p2[i] && p2[i] == p3[i]) a_new[i] = p1[i];
            else a_new[i] = a0[i];
        end
        a2 = a1; a1 = a0; a0 = a_new;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp2);
        if (model_on) model_edge();
        @(negedge cp2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
        bus.ramadr = a; bus.dbus_in = d; bus.ramwe = 1'b1;
        tick();
        bus.ramwe = 1'b0;
    endtask

    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        bus.IO_Addr = a; bus.dbus_in = d; bus.iowe = 1'b1;
        tick();
        bus.iowe = 1'b0;
    endtask

    task automatic rd_io(input logic [5:0] a, output logic [8:0] r);
        bus.IO_Addr = a; bus.iore = 1'b1;
        #1 r = {bus.out_en, bus.dbus_out};
        bus.iore = 1'b0;
    endtask

    task automatic rd_ram(input logic [7:0] a, output logic [8:0] r);
        bus.ramadr = a; bus.ramre = 1'b1;
        #1 r = {bus.dm_out_en, bus.dm_dbus_out};
        bus.ramre = 1'b0;
    endtask

    task automatic chk_flag(input string name, input logic [7:0] exp_fr, input logic exp_irq);
        logic [8:0] r;
        rd_io(6'h1B, r);
        chk({name, "_pcifr"}, 32'(r), {23'd0, 1'b1, exp_fr});
        chk({name, "_irq"}, 32'(pcint_irq[0]), 32'(exp_irq));
    endtask

    typedef struct {
        string      name;
        bit         io;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         exp_en;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt [$];

    initial begin
        logic [8:0]  r;
        logic [7:0]  addr_tab [7];
        bit          fast;

        bus.IO_Addr = '0; bus.iore = 0; bus.iowe = 0; bus.dbus_in = '0;
        bus.ramadr = '0; bus.ramre = 0; bus.ramwe = 0;
        model_reset();

        vt.push_back('{"rst_pcifr",  1, 0, 8'h1B, 8'h00, 1, 8'h00});
        vt.push_back('{"rst_pcicr",  0, 0, 8'h68, 8'h00, 1, 8'h00});
        vt.push_back('{"rst_pcmsk0", 0, 0, 8'h6B, 8'h00, 1, 8'h00});
        vt.push_back('{"rst_pcmsk1", 0, 0, 8'h6C, 8'h00, 1, 8'h00});
        vt.push_back('{"rst_pcmsk2", 0, 0, 8'h6D, 8'h00, 1, 8'h00});
        vt.push_back('{"rst_pcmsk3", 0, 0, 8'h6E, 8'h00, 1, 8'h00});
        vt.push_back('{"pcicr_width",0, 1, 8'h68, 8'hFF, 1, 8'h0F});
        vt.push_back('{"pcmsk0_wr",  0, 1, 8'h6B, 8'hA5, 1, 8'hA5});
        vt.push_back('{"pcmsk1_wr",  0, 1, 8'h6C, 8'h5A, 1, 8'h5A});
        vt.push_back('{"pcmsk2_wr",  0, 1, 8'h6D, 8'h3C, 1, 8'h3C});
        vt.push_back('{"pcmsk3_wr",  0, 1, 8'h6E, 8'hC3, 1, 8'hC3});
        vt.push_back('{"pcmsk_oob",  0, 0, 8'h6F, 8'h00, 0, 8'h00});
        vt.push_back('{"pcmsk_low",  0, 0, 8'h6A, 8'h00, 0, 8'h00});
        vt.push_back('{"io_miss",    1, 0, 8'h1A, 8'h00, 0, 8'h00});
        vt.push_back('{"pcifr_w1_idle", 1, 1, 8'h1B, 8'hFF, 1, 8'h00});

        // reset state while ireset is held
        #2;
        chk("rst_irq", 32'(pcint_irq), 0);
        chk("rst_pcie", 32'(PCIE), 0);
        chk("rst_pcint", PCINT, 0);
        @(negedge cp2);
        ireset = 1'b1;
        tick();

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                if (vt[i].io) io_wr(vt[i].addr[5:0], vt[i].wdata);
                else ram_wr(vt[i].addr, vt[i].wdata);
            end
            if (vt[i].io) rd_io(vt[i].addr[5:0], r);
            else rd_ram(vt[i].addr, r);
            chk(vt[i].name, 32'(r), {23'd0, vt[i].exp_en, vt[i].exp_rd});
            tick();
        end
        chk("pcint_out", PCINT, 32'hC33C5AA5);
        chk("pcie_out", 32'(PCIE), 32'h0000000F);
        chk("no_flag_static", 32'(pcint_irq), 0);
        ram_wr(8'h68, 8'h00);
        for (int g = 0; g < 4; g++) ram_wr(8'h6B + 8'(g), 8'h00);

        // basic detection latency, unmasked pin ignored
        ram_wr(8'h68, 8'h01);
        ram_wr(8'h6B, 8'h04);
        pin_i[2] = 1'b1;
        ticks(LAT);
        chk_flag("lat_early", 8'h00, 1'b0);
        tick();
        chk_flag("lat_set", 8'h01, 1'b1);
        io_wr(6'h1B, 8'h01);
        chk_flag("w1c", 8'h00, 1'b0);
        pin_i[3] = 1'b1;
        ticks(LAT + 3);
        chk_flag("unmasked", 8'h00, 1'b0);

        // set beats a same-cycle write-1 clear
        pin_i[2] = 1'b0;
        ticks(LAT + 1);
        chk_flag("pre_race", 8'h01, 1'b1);
        pin_i[2] = 1'b1;
        ticks(LAT);
        bus.IO_Addr = 6'h1B; bus.dbus_in = 8'h01; bus.iowe = 1'b1;
        tick();
        bus.iowe = 1'b0;
        chk_flag("set_beats_clr", 8'h01, 1'b1);
        io_wr(6'h1B, 8'h01);
        chk_flag("clr_after_race", 8'h00, 1'b0);

        // vector acknowledge, only the own group's ack clears
        pin_i[2] = 1'b0;
        ticks(LAT + 1);
        irq_ack = 4'b0010;
        tick();
        irq_ack = 4'b0000;
        chk_flag("ack_other_grp", 8'h01, 1'b1);
        irq_ack = 4'b0001;
        tick();
        irq_ack = 4'b0000;
        chk_flag("ack_own_grp", 8'h00, 1'b0);

        // disabling PCIE keeps the flag but drops the request
        pin_i[2] = 1'b1;
        ticks(LAT + 1);
        ram_wr(8'h68, 8'h00);
        chk_flag("pcie_off", 8'h01, 1'b0);
        ram_wr(8'h68, 8'h01);
        chk_flag("pcie_on", 8'h01, 1'b1);
        io_wr(6'h1B, 8'h01);

        // enabling while the pin is static raises nothing
        ram_wr(8'h68, 8'h00);
        ram_wr(8'h6B, 8'h00);
        pin_i[2] = 1'b0;
        ticks(8);
        pin_i[2] = 1'b1;
        ticks(8);
        ram_wr(8'h6B, 8'h04);
        ram_wr(8'h68, 8'h01);
        ticks(8);
        chk_flag("enable_static", 8'h00, 1'b0);
        pin_i[2] = 1'b0;
        ticks(LAT + 1);
        chk_flag("toggle_after_en", 8'h01, 1'b1);
        io_wr(6'h1B, 8'h01);

`ifdef PCINT_GLITCH_FILTER_EN
        pin_i[2] = 1'b1;
        ticks(2);
        pin_i[2] = 1'b0;
        ticks(10);
        chk_flag("glitch_2cyc", 8'h00, 1'b0);
        pin_i[2] = 1'b1;
        ticks(4);
        pin_i[2] = 1'b0;
        ticks(10);
        chk_flag("pulse_4cyc", 8'h01, 1'b1);
`else
        pin_i[2] = 1'b1;
        tick();
        pin_i[2] = 1'b0;
        ticks(8);
        chk_flag("pulse_1cyc", 8'h01, 1'b1);
`endif
        io_wr(6'h1B, 8'h01);

        // reset in the middle of a pulse with a pending flag
        pin_i[2] = 1'b1;
        ticks(LAT + 1);
        pin_i[2] = 1'b0;
        tick();
        #1 ireset = 1'b0;
        #1;
        chk("rstmid_irq", 32'(pcint_irq), 0);
        chk("rstmid_pcie", 32'(PCIE), 0);
        chk("rstmid_pcint", PCINT, 0);
        rd_io(6'h1B, r);
        chk("rstmid_pcifr", 32'(r), 32'h100);
        @(negedge cp2);
        ireset = 1'b1;
        ticks(LAT + 3);
        rd_io(6'h1B, r);
        chk("post_rst_pcifr", 32'(r), 32'h100);
        tick();

        // randomized run against the reference model
        ireset = 1'b0;
        pin_i = '0;
        model_reset();
        @(negedge cp2);
        ireset = 1'b1;
        model_on = 1'b1;
        addr_tab = '{8'h68, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h10};
        bus.IO_Addr = 6'h1B;
        bus.iore = 1'b1;
        fast = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 32 == 0) fast = 1'($urandom_range(0, 1));
            for (int i = 0; i < 32; i++)
                if ($urandom_range(0, fast ? 3 : 15) == 0) pin_i[i] = ~pin_i[i];
            irq_ack     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            bus.iowe    = ($urandom_range(0, 9) == 0);
            bus.ramwe   = ($urandom_range(0, 7) == 0);
            bus.ramadr  = addr_tab[$urandom_range(0, 6)];
            bus.dbus_in = 8'($urandom);
            tick();
            chk("rnd_pcifr", 32'(bus.dbus_out), 32'(flag_m));
            chk("rnd_irq", 32'(pcint_irq), 32'(flag_m & pcie_m));
            chk("rnd_pcie", 32'(PCIE), 32'(pcie_m));
            chk("rnd_pcint", PCINT, {msk_m[3], msk_m[2], msk_m[1], msk_m[0]});
        end
        bus.iore = 1'b0; bus.iowe = 1'b0; bus.ramwe = 1'b0; irq_ack = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
